// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipelined MIPS control unit: opcode/funct values,
// ALU and access-size codes, FSM states and the per-stage control words.
package pipeline_ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (HALT is an R-type with funct 6'h3F)
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_HALT  = 6'h3F;

  localparam int ALU_OP_W = 3;
  localparam logic [ALU_OP_W-1:0] ALU_LSA    = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_BRANCH = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_RTYPE  = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_ADDI   = 3'b011;

  localparam logic [1:0] BHW_NONE = 2'b00;
  localparam logic [1:0] BHW_HALF = 2'b01;
  localparam logic [1:0] BHW_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Controls consumed in WB
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  // Controls consumed in MEM plus everything still travelling to WB
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [1:0] bhw;
    wb_ctrl_t   wb;
  } mem_ctrl_t;

  // Controls consumed in EX plus everything still travelling downstream
  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                reg_dst;
    logic                alu_src;
    logic                jal_sel;
    mem_ctrl_t           mem;
  } ex_ctrl_t;

  // Full decode: ID-stage signals plus the word launched into EX
  typedef struct packed {
    logic     branch;
    logic     equal;
    logic     jump;
    logic     jump_sel;
    logic     bds_sel;
    ex_ctrl_t ex;
  } ctrl_word_t;

endpackage

// File: rtl/pipeline_ctrl_unit_decoder.sv
// Pure combinational opcode/funct decoder. Unknown encodings produce an
// all-zero word, which downstream is indistinguishable from a bubble.
module ctrl_decoder
  import pipeline_ctrl_pkg::*;
#(
  parameter int OPCODE_SZ = 6,
  parameter int FUNCT_SZ  = 6
) (
  input  logic [OPCODE_SZ-1:0] op_i,
  input  logic [FUNCT_SZ-1:0]  funct_i,
  output ctrl_word_t           ctrl_o,
  output logic                 is_halt_o
);

  // Table decode of the instruction into its full control word
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    ctrl_o    = '0;
    is_halt_o = 1'b0;
    case (op_i)
      OPCODE_SZ'(OP_RTYPE): begin
        if (funct_i == FUNCT_SZ'(FN_HALT)) begin
          is_halt_o = 1'b1;
        end else begin
          ctrl_o.ex.reg_dst          = 1'b1;
          ctrl_o.ex.alu_op           = ALU_RTYPE;
          ctrl_o.ex.mem.wb.reg_write = (funct_i != FUNCT_SZ'(FN_JR));
          if (funct_i == FUNCT_SZ'(FN_JR) || funct_i == FUNCT_SZ'(FN_JALR)) begin
            ctrl_o.jump     = 1'b1;
            ctrl_o.jump_sel = 1'b1;
            ctrl_o.bds_sel  = 1'b1;
          end
        end
      end
      OPCODE_SZ'(OP_LW), OPCODE_SZ'(OP_LH): begin
        ctrl_o.ex.alu_src           = 1'b1;
        ctrl_o.ex.alu_op            = ALU_LSA;
        ctrl_o.ex.mem.mem_read      = 1'b1;
        ctrl_o.ex.mem.bhw           = (op_i == OPCODE_SZ'(OP_LW)) ? BHW_WORD : BHW_HALF;
        ctrl_o.ex.mem.wb.mem_to_reg = 1'b1;
        ctrl_o.ex.mem.wb.reg_write  = 1'b1;
      end
      OPCODE_SZ'(OP_SW): begin
        ctrl_o.ex.alu_src       = 1'b1;
        ctrl_o.ex.alu_op        = ALU_LSA;
        ctrl_o.ex.mem.mem_write = 1'b1;
        ctrl_o.ex.mem.bhw       = BHW_WORD;
      end
      OPCODE_SZ'(OP_ADDI): begin
        ctrl_o.ex.alu_src          = 1'b1;
        ctrl_o.ex.alu_op           = ALU_ADDI;
        ctrl_o.ex.mem.wb.reg_write = 1'b1;
      end
      OPCODE_SZ'(OP_BEQ), OPCODE_SZ'(OP_BNE): begin
        ctrl_o.branch    = 1'b1;
        ctrl_o.equal     = (op_i == OPCODE_SZ'(OP_BEQ));
        ctrl_o.bds_sel   = 1'b1;
        ctrl_o.ex.alu_op = ALU_BRANCH;
      end
      OPCODE_SZ'(OP_J), OPCODE_SZ'(OP_JAL): begin
        ctrl_o.jump    = 1'b1;
        ctrl_o.bds_sel = 1'b1;
        if (op_i == OPCODE_SZ'(OP_JAL)) begin
          ctrl_o.ex.jal_sel          = 1'b1;
          ctrl_o.ex.mem.wb.reg_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipelined control unit: decodes ID, carries the control word through the
// EX/MEM/WB stage registers, inserts bubbles for stall/flush and owns the
// HALT drain FSM and single-step gating.
module pipeline_ctrl_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int OPCODE_SZ    = 6,
  parameter int FUNCT_SZ     = 6,
  parameter int ALU_OP_SZ    = 3,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [OPCODE_SZ-1:0] i_instr_op_D,
  input  logic [FUNCT_SZ-1:0]  i_instr_funct_D,
  input  logic                 i_valid_D,
  input  logic                 i_stall,
  input  logic                 i_flush_D,
  input  logic                 i_step_mode,
  input  logic                 i_step,
  output logic                 o_branch_D,
  output logic                 o_equal_D,
  output logic                 o_jump_D,
  output logic                 o_jump_sel_D,
  output logic                 o_bds_sel_D,
  output logic [ALU_OP_SZ-1:0] o_alu_op_E,
  output logic                 o_reg_dst_E,
  output logic                 o_alu_src_E,
  output logic                 o_jal_sel_E,
  output logic                 o_mem_read_M,
  output logic                 o_mem_write_M,
  output logic [1:0]           o_bhw_M,
  output logic                 o_reg_write_W,
  output logic                 o_mem_to_reg_W,
  output logic                 o_pc_write,
  output logic                 o_draining,
  output logic                 o_halted
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_word_t dec;
  logic       is_halt;
  logic       adv;
  logic       bubble_d;
  logic       halt_go;
  ex_ctrl_t   ex_d;
  ex_ctrl_t   ex_q;
  mem_ctrl_t  mem_q;
  wb_ctrl_t   wb_q;
  state_e     state_q;
  logic [CNT_W-1:0] cnt_q;

  ctrl_decoder #(
    .OPCODE_SZ (OPCODE_SZ),
    .FUNCT_SZ  (FUNCT_SZ)
  ) u_decoder (
    .op_i      (i_instr_op_D),
    .funct_i   (i_instr_funct_D),
    .ctrl_o    (dec),
    .is_halt_o (is_halt)
  );

  assign adv = ~i_step_mode | i_step;

  // Bubble selection for the word launched into EX; flush and stall both
  // collapse to the same all-zero word, so their priority is moot
  always_comb begin
    bubble_d = ~i_valid_D | i_stall | i_flush_D | (state_q != ST_RUN) | is_halt;
    ex_d     = bubble_d ? '0 : dec.ex;
    halt_go  = adv & i_valid_D & ~i_stall & ~i_flush_D & is_halt & (state_q == ST_RUN);
  end

  // ID-stage decode is only visible for an instruction that will really issue
  assign o_branch_D   = dec.branch   & ~bubble_d;
  assign o_equal_D    = dec.equal    & ~bubble_d;
  assign o_jump_D     = dec.jump     & ~bubble_d;
  assign o_jump_sel_D = dec.jump_sel & ~bubble_d;
  assign o_bds_sel_D  = dec.bds_sel  & ~bubble_d;

  // Fetch freezes on stall, outside RUN, and already on the cycle HALT issues
  // so nothing behind it is fetched
  assign o_pc_write = ~i_reset & adv & ~i_stall & (state_q == ST_RUN) & ~halt_go;

  // Stage registers: shift on every advancing cycle, hold otherwise
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all stages update together.
    if (i_reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (adv) begin
      ex_q  <= ex_d;
      mem_q <= ex_q.mem;
      wb_q  <= mem_q.wb;
    end
  end

  // HALT drain FSM: RUN -> DRAIN for DRAIN_CYCLES advancing cycles -> HALTED
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else if (adv) begin
      case (state_q)
        ST_RUN: begin
          if (halt_go) begin
            state_q <= ST_DRAIN;
            cnt_q   <= CNT_W'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (cnt_q == '0) state_q <= ST_HALTED;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: state_q <= ST_HALTED;
      endcase
    end
  end

  assign o_draining = (state_q == ST_DRAIN);
  assign o_halted   = (state_q == ST_HALTED);

  assign o_alu_op_E     = ALU_OP_SZ'(ex_q.alu_op);
  assign o_reg_dst_E    = ex_q.reg_dst;
  assign o_alu_src_E    = ex_q.alu_src;
  assign o_jal_sel_E    = ex_q.jal_sel;
  assign o_mem_read_M   = mem_q.mem_read;
  assign o_mem_write_M  = mem_q.mem_write;
  assign o_bhw_M        = mem_q.bhw;
  assign o_reg_write_W  = wb_q.reg_write;
  assign o_mem_to_reg_W = wb_q.mem_to_reg;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed bench for pipeline_ctrl_unit. Each step pushes the expected word
// launched into EX onto a scoreboard queue; the queue front is what EX must
// show, the next entries what MEM and WB must show.
module tb_pipeline_ctrl_unit;

  typedef struct packed {
    logic       branch;
    logic       equal;
    logic       jump;
    logic       jump_sel;
    logic       bds_sel;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       alu_src;
    logic       jal_sel;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] bhw;
    logic       reg_write;
    logic       mem_to_reg;
  } tb_ctrl_t;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [5:0] i_instr_op_D;
  logic [5:0] i_instr_funct_D;
  logic       i_valid_D, i_stall, i_flush_D, i_step_mode, i_step;
  logic       o_branch_D, o_equal_D, o_jump_D, o_jump_sel_D, o_bds_sel_D;
  logic [2:0] o_alu_op_E;
  logic       o_reg_dst_E, o_alu_src_E, o_jal_sel_E;
  logic       o_mem_read_M, o_mem_write_M;
  logic [1:0] o_bhw_M;
  logic       o_reg_write_W, o_mem_to_reg_W;
  logic       o_pc_write, o_draining, o_halted;

  int checks = 0;
  int errors = 0;

  tb_ctrl_t pipe_q[$];
  int       m_st;   // 0 RUN, 1 DRAIN, 2 HALTED
  int       m_cnt;

  pipeline_ctrl_unit dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_instr_op_D    (i_instr_op_D),
    .i_instr_funct_D (i_instr_funct_D),
    .i_valid_D       (i_valid_D),
    .i_stall         (i_stall),
    .i_flush_D       (i_flush_D),
    .i_step_mode     (i_step_mode),
    .i_step          (i_step),
    .o_branch_D      (o_branch_D),
    .o_equal_D       (o_equal_D),
    .o_jump_D        (o_jump_D),
    .o_jump_sel_D    (o_jump_sel_D),
    .o_bds_sel_D     (o_bds_sel_D),
    .o_alu_op_E      (o_alu_op_E),
    .o_reg_dst_E     (o_reg_dst_E),
    .o_alu_src_E     (o_alu_src_E),
    .o_jal_sel_E     (o_jal_sel_E),
    .o_mem_read_M    (o_mem_read_M),
    .o_mem_write_M   (o_mem_write_M),
    .o_bhw_M         (o_bhw_M),
    .o_reg_write_W   (o_reg_write_W),
    .o_mem_to_reg_W  (o_mem_to_reg_W),
    .o_pc_write      (o_pc_write),
    .o_draining      (o_draining),
    .o_halted        (o_halted)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written straight from the instruction table
  function automatic tb_ctrl_t tb_decode(input logic [5:0] op, input logic [5:0] fn);
    tb_ctrl_t c;
    c = '0;
    case (op)
      6'h00: if (fn != 6'h3F) begin
        c.reg_dst   = 1'b1;
        c.alu_op    = 3'b010;
        c.reg_write = (fn != 6'h08);
        if (fn == 6'h08 || fn == 6'h09) begin
          c.jump = 1'b1; c.jump_sel = 1'b1; c.bds_sel = 1'b1;
        end
      end
      6'h23: begin c.alu_src = 1; c.mem_read = 1; c.mem_to_reg = 1; c.reg_write = 1; c.bhw = 2'b11; end
      6'h21: begin c.alu_src = 1; c.mem_read = 1; c.mem_to_reg = 1; c.reg_write = 1; c.bhw = 2'b01; end
      6'h2B: begin c.alu_src = 1; c.mem_write = 1; c.bhw = 2'b11; end
      6'h08: begin c.alu_src = 1; c.reg_write = 1; c.alu_op = 3'b011; end
      6'h04: begin c.branch = 1; c.equal = 1; c.alu_op = 3'b001; c.bds_sel = 1; end
      6'h05: begin c.branch = 1; c.alu_op = 3'b001; c.bds_sel = 1; end
      6'h02: begin c.jump = 1; c.bds_sel = 1; end
      6'h03: begin c.jump = 1; c.bds_sel = 1; c.jal_sel = 1; c.reg_write = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic check_stages(input string tag);
    check({tag, ".ex"},  18'({o_alu_op_E, o_reg_dst_E, o_alu_src_E, o_jal_sel_E}),
          18'({pipe_q[0].alu_op, pipe_q[0].reg_dst, pipe_q[0].alu_src, pipe_q[0].jal_sel}));
    check({tag, ".mem"}, 18'({o_mem_read_M, o_mem_write_M, o_bhw_M}),
          18'({pipe_q[1].mem_read, pipe_q[1].mem_write, pipe_q[1].bhw}));
    check({tag, ".wb"},  18'({o_reg_write_W, o_mem_to_reg_W}),
          18'({pipe_q[2].reg_write, pipe_q[2].mem_to_reg}));
    check({tag, ".draining"}, 18'(o_draining), 18'(m_st == 1));
    check({tag, ".halted"},   18'(o_halted),   18'(m_st == 2));
  endtask

  // One clock of stimulus: drive at the falling edge, check the ID-stage
  // combinational outputs, then check the registered outputs a half cycle
  // after the rising edge.
  task automatic apply(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic v, input logic s, input logic f,
                       input logic sm, input logic st);
    tb_ctrl_t d, e;
    logic adv, halt, bub, halt_go, exp_pc;
    i_instr_op_D = op; i_instr_funct_D = fn; i_valid_D = v;
    i_stall = s; i_flush_D = f; i_step_mode = sm; i_step = st;
    #1;
    adv     = ~sm | st;
    d       = tb_decode(op, fn);
    halt    = (op == 6'h00) && (fn == 6'h3F);
    bub     = ~v | s | f | (m_st != 0) | halt;
    e       = bub ? tb_ctrl_t'('0) : d;
    halt_go = adv & v & ~s & ~f & halt & (m_st == 0);
    exp_pc  = adv & ~s & (m_st == 0) & ~halt_go;
    check({tag, ".id"}, 18'({o_branch_D, o_equal_D, o_jump_D, o_jump_sel_D, o_bds_sel_D}),
          18'({e.branch, e.equal, e.jump, e.jump_sel, e.bds_sel}));
    check({tag, ".pc_write"}, 18'(o_pc_write), 18'(exp_pc));
    @(posedge i_clk);
    if (adv) begin
      pipe_q.push_front(e);
      void'(pipe_q.pop_back());
      if (m_st == 0 && halt_go) begin
        m_st = 1; m_cnt = 2;
      end else if (m_st == 1) begin
        if (m_cnt == 0) m_st = 2;
        else            m_cnt = m_cnt - 1;
      end
    end
    @(negedge i_clk);
    check_stages(tag);
  endtask

  task automatic nop(input string tag);
    apply(tag, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    i_reset = 1'b1;
    i_valid_D = 1'b0; i_stall = 1'b0; i_flush_D = 1'b0;
    i_step_mode = 1'b0; i_step = 1'b0;
    i_instr_op_D = 6'h00; i_instr_funct_D = 6'h00;
    @(posedge i_clk);
    #1;
    check({tag, ".pc_write_in_reset"}, 18'(o_pc_write), 18'(0));
    pipe_q.delete();
    repeat (3) pipe_q.push_back(tb_ctrl_t'('0));
    m_st = 0; m_cnt = 0;
    @(negedge i_clk);
    check_stages(tag);
    i_reset = 1'b0;
  endtask

  initial begin
    do_reset("reset");

    // ADDU flows through to WB
    apply("addu", 6'h00, 6'h21, 1, 0, 0, 0, 0);
    nop("addu_n1"); nop("addu_n2"); nop("addu_n3");

    // LW held in ID by a stall, then issued
    apply("lw_stall", 6'h23, 6'h00, 1, 1, 0, 0, 0);
    apply("lw_go",    6'h23, 6'h00, 1, 0, 0, 0, 0);
    nop("lw_n1"); nop("lw_n2");

    // Flushed BEQ, then SW unaffected
    apply("beq_flush", 6'h04, 6'h00, 1, 0, 1, 0, 0);
    apply("sw",        6'h2B, 6'h00, 1, 0, 0, 0, 0);
    nop("sw_n1"); nop("sw_n2");

    // Remaining table entries back to back, plus an unknown opcode
    apply("lh",    6'h21, 6'h00, 1, 0, 0, 0, 0);
    apply("jr",    6'h00, 6'h08, 1, 0, 0, 0, 0);
    apply("jalr",  6'h00, 6'h09, 1, 0, 0, 0, 0);
    apply("j",     6'h02, 6'h00, 1, 0, 0, 0, 0);
    apply("jal",   6'h03, 6'h00, 1, 0, 0, 0, 0);
    apply("bne",   6'h05, 6'h00, 1, 0, 0, 0, 0);
    apply("beq",   6'h04, 6'h00, 1, 0, 0, 0, 0);
    apply("sll",   6'h00, 6'h00, 1, 0, 0, 0, 0);
    apply("unk",   6'h3E, 6'h00, 1, 0, 0, 0, 0);
    apply("stall_flush", 6'h08, 6'h00, 1, 1, 1, 0, 0);
    nop("tbl_n1"); nop("tbl_n2"); nop("tbl_n3");

    // Single-step: ADDI waits in ID until the step pulse
    for (int k = 0; k < 5; k++) apply("step_hold", 6'h08, 6'h00, 1, 0, 0, 1, 0);
    apply("step_pulse", 6'h08, 6'h00, 1, 0, 0, 1, 1);
    apply("step_idle",  6'h00, 6'h00, 0, 0, 0, 1, 0);
    nop("step_n1"); nop("step_n2"); nop("step_n3");

    // Stalled and flushed HALTs must not start the drain
    apply("halt_stalled", 6'h00, 6'h3F, 1, 1, 0, 0, 0);
    apply("halt_flushed", 6'h00, 6'h3F, 1, 0, 1, 0, 0);

    // Real HALT with ops in flight; stall during drain is ignored
    apply("pre_lw",  6'h23, 6'h00, 1, 0, 0, 0, 0);
    apply("pre_sw",  6'h2B, 6'h00, 1, 0, 0, 0, 0);
    apply("halt",    6'h00, 6'h3F, 1, 0, 0, 0, 0);
    apply("drain1",  6'h08, 6'h00, 1, 1, 0, 0, 0);
    apply("drain2",  6'h08, 6'h00, 1, 0, 1, 0, 0);
    apply("drain3",  6'h08, 6'h00, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) apply("halted", 6'h08, 6'h00, 1, 0, 0, 0, 0);

    // Reset out of HALTED, then reset mid-drain with counter at 1
    do_reset("reset_halted");
    apply("halt2",   6'h00, 6'h3F, 1, 0, 0, 0, 0);
    nop("drain_c2");
    do_reset("reset_drain");
    apply("after_reset", 6'h08, 6'h00, 1, 0, 0, 0, 0);
    nop("ar_n1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
